// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine: LANES bytes of the 128-bit state
// are substituted per cycle, so one state takes 16/LANES passes.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         busy
);

    localparam int NCYC  = 16 / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
        logic [15:0] d;
        d = {a, a} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [0:15][7:0]       work_q, work_d;
    logic                   mode_q, mode_d;
    logic [3:0]             base;
    logic [7:0]             lane_sub [LANES];

    assign base = 4'(int'(cnt_q) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_in;
        assign lane_in     = work_q[base + 4'(l)];
        assign lane_sub[l] = mode_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                for (int l = 0; l < LANES; l++) work_d[base + 4'(l)] = lane_sub[l];
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_data;
                        mode_d  = in_mode;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the working register is reset too, so an aborted state never shows on out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign out_data = work_q;
    assign out_mode = mode_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: three instances (LANES = 4, 1, 16) share
// clock and reset; table vectors plus backpressure, mid-BUSY and reset sequences.
module tb_sub_bytes_engine;

    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_a  [NDUT];
    logic         in_ready_a  [NDUT];
    logic         in_mode_a   [NDUT];
    logic [127:0] in_data_a   [NDUT];
    logic         out_valid_a [NDUT];
    logic         out_ready_a [NDUT];
    logic [127:0] out_data_a  [NDUT];
    logic         out_mode_a  [NDUT];
    logic         busy_a      [NDUT];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_engine #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_mode   (in_mode_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .out_mode  (out_mode_a[g]),
            .busy      (busy_a[g])
        );
    end

    typedef struct {
        logic         mode;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    // Presents one state at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input int d, input logic mode, input logic [127:0] data);
        @(negedge clk);
        in_valid_a[d] = 1'b1;
        in_mode_a[d]  = mode;
        in_data_a[d]  = data;
        #1;
        check($sformatf("in_ready_at_accept[L%0d]", lanes_of(d)), 128'(in_ready_a[d]), 128'd1);
        @(negedge clk);
        in_valid_a[d] = 1'b0;
    endtask

    // Counts edges after the accept until out_valid, bounded.
    task automatic wait_result(input int d, output int lat);
        lat = 0;
        while (!out_valid_a[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result(input int d);
        out_ready_a[d] = 1'b1;
        @(negedge clk);
        out_ready_a[d] = 1'b0;
        check($sformatf("idle_after_release[L%0d]", lanes_of(d)), 128'(out_valid_a[d]), 128'd0);
    endtask

    initial begin
        int lat;
        logic [127:0] v0, v1, zeros;
        v0    = 128'h00112233445566778899aabbccddeeff;
        v1    = 128'h638293c31bfc33f5c4eeacea4bc12816;
        zeros = '0;

        vecs[0] = '{1'b0, v0, v1};
        vecs[1] = '{1'b1, v1, v0};
        vecs[2] = '{1'b0, zeros, {16{8'h63}}};
        vecs[3] = '{1'b1, zeros, {16{8'h52}}};
        vecs[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
        vecs[5] = '{1'b1, {16{8'hff}}, {16{8'h7d}}};
        vecs[6] = '{1'b0, {16{8'h53}}, {16{8'hed}}};
        vecs[7] = '{1'b1, {16{8'hed}}, {16{8'h53}}};

        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d]  = 1'b0;
            in_mode_a[d]   = 1'b0;
            in_data_a[d]   = '0;
            out_ready_a[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < NDUT; d++) begin
            check("reset_out_valid", 128'(out_valid_a[d]), 128'd0);
            check("reset_busy",      128'(busy_a[d]),      128'd0);
            check("reset_out_data",  out_data_a[d],        128'd0);
            check("reset_out_mode",  128'(out_mode_a[d]),  128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_in_ready", 128'(in_ready_a[d]), 128'd1);
        end

        // out_ready with nothing to deliver must not disturb IDLE.
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        check("stray_out_ready_valid", 128'(out_valid_a[0]), 128'd0);
        check("stray_out_ready_busy",  128'(busy_a[0]),      128'd0);
        check("stray_out_ready_ready", 128'(in_ready_a[0]),  128'd1);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) begin
                accept(d, vecs[i].mode, vecs[i].data);
                wait_result(d, lat);
                check($sformatf("latency[L%0d,v%0d]", lanes_of(d), i), 128'(lat), 128'(16 / lanes_of(d)));
                check($sformatf("data[L%0d,v%0d]", lanes_of(d), i), out_data_a[d], vecs[i].exp);
                check($sformatf("mode[L%0d,v%0d]", lanes_of(d), i), 128'(out_mode_a[d]), 128'(vecs[i].mode));
                release_result(d);
            end
        end

        // Backpressure in DONE, then same-edge handover.
        accept(0, 1'b0, v0);
        wait_result(0, lat);
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
            check("bp_out_data",  out_data_a[0],        v1);
            check("bp_in_ready",  128'(in_ready_a[0]),  128'd0);
            @(negedge clk);
        end
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        in_mode_a[0]   = 1'b1;
        in_data_a[0]   = v1;
        #1;
        check("handover_in_ready", 128'(in_ready_a[0]), 128'd1);
        @(negedge clk);
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        check("handover_busy",      128'(busy_a[0]),      128'd1);
        check("handover_out_valid", 128'(out_valid_a[0]), 128'd0);
        wait_result(0, lat);
        check("handover_latency", 128'(lat), 128'd4);
        check("handover_data",    out_data_a[0], v0);
        check("handover_mode",    128'(out_mode_a[0]), 128'd1);
        release_result(0);

        // Inputs churn while BUSY; the latched state and mode must win.
        accept(0, 1'b0, zeros);
        lat = 0;
        while (!out_valid_a[0] && lat < 64) begin
            in_mode_a[0]  = ~in_mode_a[0];
            in_data_a[0]  = {$urandom, $urandom, $urandom, $urandom};
            in_valid_a[0] = 1'b1;
            @(negedge clk);
            lat++;
        end
        in_valid_a[0] = 1'b0;
        check("churn_latency", 128'(lat), 128'd4);
        check("churn_data",    out_data_a[0], {16{8'h63}});
        check("churn_mode",    128'(out_mode_a[0]), 128'd0);
        release_result(0);

        // Asynchronous reset with the pass counter at 2.
        accept(0, 1'b0, v0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid_a[0]), 128'd0);
        check("abort_busy",      128'(busy_a[0]),      128'd0);
        check("abort_in_ready",  128'(in_ready_a[0]),  128'd1);
        check("abort_out_data",  out_data_a[0],        128'd0);
        check("abort_out_mode",  128'(out_mode_a[0]),  128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(0, 1'b1, zeros);
        wait_result(0, lat);
        check("post_abort_latency", 128'(lat), 128'd4);
        check("post_abort_data",    out_data_a[0], {16{8'h52}});
        check("post_abort_mode",    128'(out_mode_a[0]), 128'd1);
        release_result(0);
        accept(0, 1'b0, v0);
        wait_result(0, lat);
        check("post_abort_fwd_data", out_data_a[0], v1);
        release_result(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
